// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the frame-buffer port arbiter: grant encoding and
// the default RGB444 pixel / frame-buffer address widths.
package vram_arbiter_pkg;

  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 12;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_W0   = 2'd2,
    GNT_W1   = 2'd3
  } gnt_e;

endpackage

// File: rtl/vram_rd_pipe.sv
// Read-return pipeline: tracks in-flight reads through the RAM latency,
// captures the RAM output and registers it toward scan-out.
module vram_rd_pipe
  import vram_arbiter_pkg::*;
#(
  parameter int DATA_W  = VRAM_DATA_W,
  parameter int RAM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              issue,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  // vld[i] marks a read issued i+1 cycles ago; vld[RAM_LAT-1] lines up with
  // MEM_RDATA being valid, vld[RAM_LAT] with rdata_q holding it.
  logic [RAM_LAT:0]  vld;
  logic [DATA_W-1:0] rdata_q;

  // NOTE: non-blocking (<=) in clocked blocks so every register samples the
  // pre-edge value of its source; blocking here would collapse the shift.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: data registers are reset too, so RD_DATA reads 0 after reset;
      // the in-flight valid bits must clear so a discarded read never returns.
      vld      <= '0;
      rdata_q  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      vld      <= {vld[RAM_LAT-1:0], issue};
      rd_valid <= vld[RAM_LAT];
      if (vld[RAM_LAT-1]) rdata_q <= mem_rdata;
      if (vld[RAM_LAT])   rd_data <= rdata_q;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads have absolute priority,
// two pixel writers share leftover cycles round-robin with a one-cycle lockout.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = VRAM_ADDR_W,
  parameter int DATA_W  = VRAM_DATA_W,
  parameter int RAM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RD_REQ,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  input  logic              W0_REQ,
  input  logic [ADDR_W-1:0] W0_ADDR,
  input  logic [DATA_W-1:0] W0_DATA,
  output logic              W0_GNT,
  input  logic              W1_REQ,
  input  logic [ADDR_W-1:0] W1_ADDR,
  input  logic [DATA_W-1:0] W1_DATA,
  output logic              W1_GNT,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  gnt_e sel;
  logic last_w;
  logic lock0, lock1;
  logic elig0, elig1;

  // A writer granted at the last edge sits out this one: the grant pulse
  // itself is the lock, so it expires whatever wins this cycle.
  assign lock0 = W0_GNT;
  assign lock1 = W1_GNT;
  assign elig0 = W0_REQ && !lock0;
  assign elig1 = W1_REQ && !lock1;

  // NOTE: sel gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel = GNT_NONE;
    if (RD_REQ)              sel = GNT_RD;
    else if (elig0 && elig1) sel = last_w ? GNT_W0 : GNT_W1;
    else if (elig0)          sel = GNT_W0;
    else if (elig1)          sel = GNT_W1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      W0_GNT    <= 1'b0;
      W1_GNT    <= 1'b0;
      last_w    <= 1'b1;
    end else begin
      MEM_EN <= (sel != GNT_NONE);
      MEM_WE <= (sel == GNT_W0) || (sel == GNT_W1);
      W0_GNT <= (sel == GNT_W0);
      W1_GNT <= (sel == GNT_W1);
      // Address and write data hold when idle; reads leave last_w alone.
      case (sel)
        GNT_RD: MEM_ADDR <= RD_ADDR;
        GNT_W0: begin
          MEM_ADDR  <= W0_ADDR;
          MEM_WDATA <= W0_DATA;
          last_w    <= 1'b0;
        end
        GNT_W1: begin
          MEM_ADDR  <= W1_ADDR;
          MEM_WDATA <= W1_DATA;
          last_w    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  vram_rd_pipe #(
    .DATA_W  (DATA_W),
    .RAM_LAT (RAM_LAT)
  ) u_rd_pipe (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .issue     (MEM_EN && !MEM_WE),
    .mem_rdata (MEM_RDATA),
    .rd_data   (RD_DATA),
    .rd_valid  (RD_VALID)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench: two arbiters (RAM_LAT=1 and 2) on shared stimulus, each
// with its own RAM model; monitors pop expected reads/grants as they appear.
module tb_vram_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RD_REQ;
  logic [15:0] RD_ADDR;
  logic        W0_REQ, W1_REQ;
  logic [15:0] W0_ADDR, W1_ADDR;
  logic [11:0] W0_DATA, W1_DATA;

  logic [11:0] rd_data1, rd_data2, mem_wdata1, mem_wdata2, dout1, dout2, s2;
  logic        rd_valid1, rd_valid2, w0_gnt1, w0_gnt2, w1_gnt1, w1_gnt2;
  logic        mem_en1, mem_en2, mem_we1, mem_we2;
  logic [15:0] mem_addr1, mem_addr2;

  logic [11:0] mem1 [0:65535];
  logic [11:0] mem2 [0:65535];

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int wr_cnt1 = 0;

  typedef struct {
    logic [11:0] data;
    int          due;
  } rd_exp_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [11:0] data;
    int          due;
  } gnt_exp_t;

  rd_exp_t  rd_q1[$], rd_q2[$];
  gnt_exp_t gnt_q[$];
  rd_exp_t  r1, r2;
  gnt_exp_t g;

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt++;

  vram_arbiter #(.ADDR_W(16), .DATA_W(12), .RAM_LAT(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_DATA(rd_data1), .RD_VALID(rd_valid1),
    .W0_REQ(W0_REQ), .W0_ADDR(W0_ADDR), .W0_DATA(W0_DATA), .W0_GNT(w0_gnt1),
    .W1_REQ(W1_REQ), .W1_ADDR(W1_ADDR), .W1_DATA(W1_DATA), .W1_GNT(w1_gnt1),
    .MEM_EN(mem_en1), .MEM_WE(mem_we1), .MEM_ADDR(mem_addr1),
    .MEM_WDATA(mem_wdata1), .MEM_RDATA(dout1)
  );

  vram_arbiter #(.ADDR_W(16), .DATA_W(12), .RAM_LAT(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_DATA(rd_data2), .RD_VALID(rd_valid2),
    .W0_REQ(W0_REQ), .W0_ADDR(W0_ADDR), .W0_DATA(W0_DATA), .W0_GNT(w0_gnt2),
    .W1_REQ(W1_REQ), .W1_ADDR(W1_ADDR), .W1_DATA(W1_DATA), .W1_GNT(w1_gnt2),
    .MEM_EN(mem_en2), .MEM_WE(mem_we2), .MEM_ADDR(mem_addr2),
    .MEM_WDATA(mem_wdata2), .MEM_RDATA(dout2)
  );

  // RAM models: one-cycle and two-cycle read latency from the MEM_EN edge.
  always @(posedge CLK) begin
    if (mem_en1 && mem_we1) begin
      mem1[mem_addr1] <= mem_wdata1;
      wr_cnt1 <= wr_cnt1 + 1;
    end
    if (mem_en1 && !mem_we1) dout1 <= mem1[mem_addr1];
  end

  always @(posedge CLK) begin
    if (mem_en2 && mem_we2)  mem2[mem_addr2] <= mem_wdata2;
    if (mem_en2 && !mem_we2) s2 <= mem2[mem_addr2];
    dout2 <= s2;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Request sampled at the next edge; RD_VALID rises 2+RAM_LAT edges later.
  task automatic push_rd(input logic [15:0] a);
    rd_exp_t e;
    e.data = a[11:0];
    e.due  = edge_cnt + 1 + 2 + 1;
    rd_q1.push_back(e);
    e.due  = edge_cnt + 1 + 2 + 2;
    rd_q2.push_back(e);
  endtask

  task automatic push_gnt(input logic wr, input logic [15:0] a, input logic [11:0] d, input int due);
    gnt_exp_t e;
    e.wr = wr; e.addr = a; e.data = d; e.due = due;
    gnt_q.push_back(e);
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_ctl1"}, {27'd0, mem_en1, mem_we1, w0_gnt1, w1_gnt1, rd_valid1}, 32'd0);
    check({tag, "_addr1"}, {16'd0, mem_addr1}, 32'd0);
    check({tag, "_wdata1"}, {20'd0, mem_wdata1}, 32'd0);
    check({tag, "_rdata1"}, {20'd0, rd_data1}, 32'd0);
    check({tag, "_ctl2"}, {27'd0, mem_en2, mem_we2, w0_gnt2, w1_gnt2, rd_valid2}, 32'd0);
    check({tag, "_addr2"}, {16'd0, mem_addr2}, 32'd0);
    check({tag, "_wdata2"}, {20'd0, mem_wdata2}, 32'd0);
    check({tag, "_rdata2"}, {20'd0, rd_data2}, 32'd0);
  endtask

  // Monitors: every DUT output event must match the head of its queue.
  always @(negedge CLK) begin
    if (rd_valid1) begin
      check("rd1_expected", {31'd0, rd_q1.size() != 0}, 32'd1);
      if (rd_q1.size() != 0) begin
        r1 = rd_q1.pop_front();
        check("rd1_data", {20'd0, rd_data1}, {20'd0, r1.data});
        check("rd1_edge", edge_cnt, r1.due);
      end
    end
    if (rd_valid2) begin
      check("rd2_expected", {31'd0, rd_q2.size() != 0}, 32'd1);
      if (rd_q2.size() != 0) begin
        r2 = rd_q2.pop_front();
        check("rd2_data", {20'd0, rd_data2}, {20'd0, r2.data});
        check("rd2_edge", edge_cnt, r2.due);
      end
    end
    if (w0_gnt1 || w1_gnt1) begin
      check("gnt_expected", {31'd0, gnt_q.size() != 0}, 32'd1);
      check("gnt_both", {31'd0, w0_gnt1 && w1_gnt1}, 32'd0);
      if (gnt_q.size() != 0) begin
        g = gnt_q.pop_front();
        check("gnt_writer", {31'd0, w1_gnt1}, {31'd0, g.wr});
        check("gnt_mem_en_we", {30'd0, mem_en1, mem_we1}, 32'd3);
        check("gnt_addr", {16'd0, mem_addr1}, {16'd0, g.addr});
        check("gnt_wdata", {20'd0, mem_wdata1}, {20'd0, g.data});
        check("gnt_edge", edge_cnt, g.due);
      end
    end
  end

  initial begin
    int base;
    int n;
    for (int i = 0; i < 65536; i++) begin
      mem1[i] = i[11:0];
      mem2[i] = i[11:0];
    end
    RST_N = 1'b0;
    RD_REQ = 1'b0; RD_ADDR = '0;
    W0_REQ = 1'b0; W0_ADDR = '0; W0_DATA = '0;
    W1_REQ = 1'b0; W1_ADDR = '0; W1_DATA = '0;
    #2;
    check_clear("por");
    tick();
    tick();
    RST_N = 1'b1;

    // Round-robin from reset: W0 wins the first tie, then strict alternation.
    base = edge_cnt;
    W0_REQ = 1'b1; W0_ADDR = 16'h0300; W0_DATA = 12'h0A0;
    W1_REQ = 1'b1; W1_ADDR = 16'h0400; W1_DATA = 12'h0B0;
    push_gnt(1'b0, 16'h0300, 12'h0A0, base + 1);
    push_gnt(1'b1, 16'h0400, 12'h0B0, base + 2);
    push_gnt(1'b0, 16'h0301, 12'h0A1, base + 3);
    push_gnt(1'b1, 16'h0401, 12'h0B1, base + 4);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (w0_gnt1) begin W0_ADDR = W0_ADDR + 16'd1; W0_DATA = W0_DATA + 12'd1; end
      if (w1_gnt1) begin W1_ADDR = W1_ADDR + 16'd1; W1_DATA = W1_DATA + 12'd1; end
    end
    W0_REQ = 1'b0; W1_REQ = 1'b0;
    repeat (3) tick();

    // Back-to-back read stream.
    for (int i = 0; i < 4; i++) begin
      RD_REQ = 1'b1; RD_ADDR = 16'h0100 + 16'(i);
      push_rd(RD_ADDR);
      tick();
    end
    RD_REQ = 1'b0;
    repeat (6) tick();

    // Read priority: W0 waits out three reads, then is granted.
    base = edge_cnt;
    W0_REQ = 1'b1; W0_ADDR = 16'h0200; W0_DATA = 12'hF00;
    push_gnt(1'b0, 16'h0200, 12'hF00, base + 4);
    for (int i = 0; i < 6; i++) begin
      RD_REQ = (i < 3);
      if (i < 3) begin
        RD_ADDR = 16'h0120 + 16'(i);
        push_rd(RD_ADDR);
      end
      tick();
      if (w0_gnt1) W0_REQ = 1'b0;
    end
    repeat (6) tick();
    check("prio_ram1_0200", {20'd0, mem1[16'h0200]}, 32'hF00);
    check("prio_ram2_0200", {20'd0, mem2[16'h0200]}, 32'hF00);

    // Lockout: a lone writer holding REQ gets every other cycle.
    wr_cnt1 = 0;
    base = edge_cnt;
    n = 0;
    W1_REQ = 1'b1; W1_ADDR = 16'h0500; W1_DATA = 12'h0C0;
    push_gnt(1'b1, 16'h0500, 12'h0C0, base + 1);
    push_gnt(1'b1, 16'h0501, 12'h0C1, base + 3);
    push_gnt(1'b1, 16'h0502, 12'h0C2, base + 5);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (w1_gnt1) begin
        n++;
        if (n == 3) W1_REQ = 1'b0;
        else begin W1_ADDR = W1_ADDR + 16'd1; W1_DATA = W1_DATA + 12'd1; end
      end
    end
    repeat (3) tick();
    check("lock_write_count", wr_cnt1, 3);
    check("lock_ram_0500", {20'd0, mem1[16'h0500]}, 32'h0C0);
    check("lock_ram_0501", {20'd0, mem1[16'h0501]}, 32'h0C1);
    check("lock_ram_0502", {20'd0, mem1[16'h0502]}, 32'h0C2);

    // Reset one cycle into a read: outputs clear at once, no RD_VALID later.
    RD_REQ = 1'b1; RD_ADDR = 16'h0010;
    tick();
    RD_REQ = 1'b0;
    tick();
    RST_N = 1'b0;
    #1;
    check_clear("midrd");
    tick();
    RST_N = 1'b1;
    repeat (8) tick();

    check("rd1_drained", rd_q1.size(), 0);
    check("rd2_drained", rd_q2.size(), 0);
    check("gnt_drained", gnt_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sequences the single port of the shared display RAM (frame buffer) between the VGA scan-out reader and two pixel writers (W0, W1).
- Scan-out reads have absolute priority, so the pixel stream never stalls.
- Writers share the remaining cycles round-robin, which in practice means mainly during blanking.
- Sits between the display-select/scan-out logic and the frame-buffer RAM.

Parameters:
- ADDR_W, 16, RAM word address width.
- DATA_W, 12, pixel width (RGB444).
- RAM_LAT, 1, RAM read latency in cycles (MEM_EN sampled to MEM_RDATA valid); legal values are 1 or 2.

Ports:
- CLK  input  1  pixel clock; all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RD_REQ  input  1  scan-out read request, single-cycle per pixel.
- RD_ADDR  input  ADDR_W  scan-out read address.
- RD_DATA  output  DATA_W  registered read data.
- RD_VALID  output  1  RD_DATA valid, one-cycle pulse per read.
- W0_REQ  input  1  writer 0 request; held with W0_ADDR and W0_DATA until granted.
- W0_ADDR  input  ADDR_W  writer 0 address.
- W0_DATA  input  DATA_W  writer 0 pixel.
- W0_GNT  output  1  one-cycle grant pulse; the write has been issued.
- W1_REQ, W1_ADDR, W1_DATA, W1_GNT: as for W0.
- MEM_EN  output  1  RAM enable (registered).
- MEM_WE  output  1  RAM write enable (registered).
- MEM_ADDR  output  ADDR_W  RAM address (registered).
- MEM_WDATA  output  DATA_W  RAM write data (registered).
- MEM_RDATA  input  DATA_W  RAM read data.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - All outputs clear to 0: MEM_*, RD_DATA, RD_VALID, W0_GNT, W1_GNT.
  - Read-valid pipeline clears.
  - LAST_W=1, so W0 wins the first tie.
  - LOCK0 and LOCK1 clear.
- Reset mid-read: the in-flight read is discarded and no RD_VALID follows.
- Arbitration, evaluated from inputs sampled at each edge:
  - RD_REQ=1: read. MEM_EN=1, MEM_WE=0, MEM_ADDR=RD_ADDR. No grants issued.
  - Otherwise the eligible writers are those with Wn_REQ=1 and LOCKn=0.
    - Two eligible: grant the writer != LAST_W.
    - One eligible: grant that writer.
    - None eligible: MEM_EN=0.
  - Write grant to n: MEM_EN=1, MEM_WE=1, MEM_ADDR=Wn_ADDR, MEM_WDATA=Wn_DATA, Wn_GNT=1 in the same cycle, LAST_W=n.
- Writer lockout:
  - A writer granted at edge k has LOCKn=1 for edge k+1 only.
  - This lets the writer see GNT and update REQ/ADDR/DATA without being written twice.
  - Consequence: a single writer gets at most 1 write every 2 cycles. Two writers alternate and can use every cycle.
- Read latency:
  - RD_REQ sampled at edge k → MEM_EN in cycle k+1 → RAM data after RAM_LAT → RD_DATA registered.
  - RD_VALID rises exactly 2+RAM_LAT edges after the RD_REQ edge, i.e. 3 for the default.
  - Implemented as a valid shift register of depth 1+RAM_LAT.
  - RD_VALID order equals RD_REQ order.
  - Back-to-back RD_REQ gives back-to-back RD_VALID.
- Idle cycles: MEM_EN=0; MEM_ADDR and MEM_WDATA hold their last value.
- Starvation: writers get no guarantee while RD_REQ is continuously 1; they are served in the blanking gaps. A writer holds REQ indefinitely until granted.
- Simultaneous RD_REQ and both writer requests: read wins. LAST_W is unchanged and locks are cleared normally.
- RD_REQ=1 during a writer's lock cycle: read issues and the lock still expires.

Decomposition:
- Shared package holds:
  - the grant encoding constants GNT_NONE, GNT_RD, GNT_W0, GNT_W1 (2 bits);
  - RGB444 DATA_W and the frame-buffer ADDR_W defaults, used by the scan-out and the writers.
- One natural sub-module: vram_rd_pipe, the parameterised valid/data return pipeline of depth RAM_LAT plus the output register.
- Arbitration stays inline.

Test Plan:
- Reset check: RST_N low mid-read, 1 cycle after RD_REQ at addr 0x0010 → all outputs 0 immediately; no RD_VALID after release.
- Read stream: RD_REQ for 4 cycles, addr 0x0100..0x0103, RAM model returns addr[11:0] → RD_VALID pulses exactly 3 edges after each request; RD_DATA=0x100..0x103 in order.
- Read priority: RD_REQ=1 and W0_REQ=1 (addr 0x0200, data 0xF00) for 3 cycles, then RD_REQ=0 → no W0_GNT while the read is active; W0_GNT one cycle after the read ends; RAM location 0x0200 = 0xF00.
- Round-robin: W0 and W1 request from reset with no reads → grants W0,W1,W0,W1 on consecutive cycles; each GNT is a single-cycle pulse; MEM_WE=1 every cycle.
- Lockout: only W1 requests, 3 pixels, REQ held continuously, ADDR/DATA advanced on each GNT → W1_GNT on cycles 1, 3, 5; exactly 3 RAM writes; no duplicate address.
- RAM_LAT=2 build: repeat the read-stream test → RD_VALID exactly 4 edges after each RD_REQ; data order preserved.
